// File: rtl/lbuf_ctl.sv
// FIFO controller for one external single-port 512x16 RAM with a 1-word input register and a 4-word output buffer.
// Optional macro LBUF_BYPASS_EN: an empty RAM and read pipe let the input word skip straight into the output buffer.
module lbuf_ctl (
  input  logic        sys_clk,
  input  logic        resetl,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        ram_cen,
  output logic        ram_rw,
  output logic [8:0]  ram_a,
  output logic [15:0] ram_d_out,
  output logic [15:0] ram_d_oe,
  input  logic [15:0] ram_d_in,
  output logic [9:0]  ram_level
);

  localparam int unsigned DW       = 16;
  localparam int unsigned AW       = 9;
  localparam int unsigned LW       = 10;
  localparam int unsigned DEPTH    = 512;
  localparam int unsigned OB_DEPTH = 4;
  localparam int unsigned OBW      = 2;
  localparam int unsigned OBCW     = 3;
  localparam int unsigned PIPE_LEN = 3;

  logic                ir_full;
  logic [DW-1:0]       ir_data;
  logic [AW-1:0]       wptr;
  logic [AW-1:0]       rptr;
  logic [LW-1:0]       level;
  logic                rd_turn;
  logic [PIPE_LEN-1:0] pipe;
  logic [DW-1:0]       ob_mem [OB_DEPTH];
  logic [OBW-1:0]      ob_wr;
  logic [OBW-1:0]      ob_rd;
  logic [OBCW-1:0]     ob_cnt;

  logic [OBCW-1:0]     inflight_c;
  logic                wr_req_c;
  logic                rd_req_c;
  logic                byp_c;
  logic                wr_gnt_c;
  logic                rd_gnt_c;
  logic                in_fire_c;
  logic                out_fire_c;
  logic                ob_push_c;
  logic [DW-1:0]       ob_push_data_c;

  // Request generation and write-first round-robin arbitration
  always_comb begin
    inflight_c = OBCW'(pipe[0]) + OBCW'(pipe[1]) + OBCW'(pipe[2]);
    wr_req_c   = ir_full && (level < LW'(DEPTH));
    rd_req_c   = (level != '0) && ((ob_cnt + inflight_c) < OBCW'(OB_DEPTH));
`ifdef LBUF_BYPASS_EN
    byp_c      = ir_full && (level == '0) && (pipe == '0) && (ob_cnt < OBCW'(OB_DEPTH));
`else
    byp_c      = 1'b0;
`endif
    wr_gnt_c   = wr_req_c && !byp_c && (!rd_req_c || !rd_turn);
    rd_gnt_c   = rd_req_c && !wr_gnt_c;
    in_ready   = !ir_full || wr_gnt_c || byp_c;
    in_fire_c  = in_valid && in_ready;
    out_valid  = (ob_cnt != '0);
    out_data   = ob_mem[ob_rd];
    out_fire_c = out_valid && out_ready;
    // Bypass needs an empty read pipe, so the two push sources never collide
    ob_push_c      = pipe[PIPE_LEN-1] || byp_c;
    ob_push_data_c = pipe[PIPE_LEN-1] ? ram_d_in : ir_data;
  end

  assign ram_level = level;

  // Input register, pointers, level and arbitration state
  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      ir_full <= 1'b0;
      ir_data <= '0;
      wptr    <= '0;
      rptr    <= '0;
      level   <= '0;
      rd_turn <= 1'b0;
      pipe    <= '0;
    end else begin
      if (in_fire_c) ir_data <= in_data;
      ir_full <= in_fire_c || (ir_full && !(wr_gnt_c || byp_c));
      if (wr_gnt_c) wptr <= wptr + AW'(1);
      if (rd_gnt_c) rptr <= rptr + AW'(1);
      level <= level + LW'(wr_gnt_c) - LW'(rd_gnt_c);
      if (wr_req_c && rd_req_c) rd_turn <= wr_gnt_c;
      pipe <= {pipe[PIPE_LEN-2:0], rd_gnt_c};
    end
  end

  // Registered RAM port; address and write data hold on idle cycles
  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      ram_cen   <= 1'b1;
      ram_rw    <= 1'b1;
      ram_a     <= '0;
      ram_d_out <= '0;
      ram_d_oe  <= '0;
    end else if (wr_gnt_c) begin
      ram_cen   <= 1'b0;
      ram_rw    <= 1'b0;
      ram_a     <= wptr;
      ram_d_out <= ir_data;
      ram_d_oe  <= '1;
    end else if (rd_gnt_c) begin
      ram_cen   <= 1'b0;
      ram_rw    <= 1'b1;
      ram_a     <= rptr;
      ram_d_oe  <= '0;
    end else begin
      ram_cen   <= 1'b1;
      ram_d_oe  <= '0;
    end
  end

  // Output buffer: circular 4-entry store
  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      for (int i = 0; i < int'(OB_DEPTH); i++) ob_mem[i] <= '0;
      ob_wr  <= '0;
      ob_rd  <= '0;
      ob_cnt <= '0;
    end else begin
      if (ob_push_c) begin
        ob_mem[ob_wr] <= ob_push_data_c;
        ob_wr         <= ob_wr + OBW'(1);
      end
      if (out_fire_c) ob_rd <= ob_rd + OBW'(1);
      ob_cnt <= ob_cnt + OBCW'(ob_push_c) - OBCW'(out_fire_c);
    end
  end

endmodule

// File: tb/tb_lbuf_ctl.sv
// Scoreboard bench for lbuf_ctl with a behavioural two-edge-latency RAM model.
module tb_lbuf_ctl;

  logic        sys_clk = 1'b0;
  logic        resetl;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        ram_cen;
  logic        ram_rw;
  logic [8:0]  ram_a;
  logic [15:0] ram_d_out;
  logic [15:0] ram_d_oe;
  logic [15:0] ram_d_in;
  logic [9:0]  ram_level;

  lbuf_ctl dut (
    .sys_clk   (sys_clk),
    .resetl    (resetl),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .ram_cen   (ram_cen),
    .ram_rw    (ram_rw),
    .ram_a     (ram_a),
    .ram_d_out (ram_d_out),
    .ram_d_oe  (ram_d_oe),
    .ram_d_in  (ram_d_in),
    .ram_level (ram_level)
  );

  always #5 sys_clk = ~sys_clk;

  // External RAM: address sampled on one edge, data valid after the next
  logic [15:0] mem [512];
  logic [15:0] rd_s1 = 16'h0;
  logic [15:0] rd_s2 = 16'h0;
  assign ram_d_in = rd_s2;
  always @(posedge sys_clk) begin
    if (!ram_cen && !ram_rw) mem[ram_a] <= ram_d_out;
    rd_s1 <= (!ram_cen && ram_rw) ? mem[ram_a] : 16'h0;
    rd_s2 <= rd_s1;
  end

  int n_total = 0;
  int n_pass  = 0;
  logic [15:0] sb [$];
  int first_wr = -1;
  int first_rd = -1;
  int cen_low_seen = 0;
  int last_wr_a = -1;
  int wrap_seen = 0;
  int want_first = 0;
  logic [8:0]  prev_a = '0;
  logic [15:0] prev_d = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
  endtask

  // Monitor: scoreboard pop/push and RAM port sanity, sampled mid-cycle
  always @(negedge sys_clk) begin
    if (resetl) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) check("unexpected_out", {16'h0, out_data}, 32'hFFFF_FFFF);
        else check("out_data", {16'h0, out_data}, {16'h0, sb.pop_front()});
        if (want_first != 0) begin
          check("first_after_reset", {16'h0, out_data}, 32'hBEEF);
          want_first = 0;
        end
      end
      if (in_valid && in_ready) sb.push_back(in_data);
      check("level_bound", 32'(ram_level <= 10'd512), 32'd1);
      if (ram_cen)
        check("ram_idle", {ram_d_oe, 7'h0, ram_a, ram_d_out}, {16'h0, 7'h0, prev_a, prev_d});
      else
        check("ram_oe", {16'h0, ram_d_oe}, ram_rw ? 32'h0 : 32'hFFFF);
      if (!ram_cen) begin
        cen_low_seen++;
        if (!ram_rw) begin
          if (first_wr < 0) first_wr = int'(ram_a);
          if (last_wr_a == 511 && ram_a == 9'd0) wrap_seen = 1;
          last_wr_a = int'(ram_a);
        end else if (first_rd < 0) first_rd = int'(ram_a);
      end
    end
    prev_a = ram_a;
    prev_d = ram_d_out;
  end

  task automatic chk_reset_outs(input string tag);
    check({tag, "_in_ready"},  32'(in_ready),  32'd1);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_data"},  32'(out_data),  32'd0);
    check({tag, "_ram_cen"},   32'(ram_cen),   32'd1);
    check({tag, "_ram_rw"},    32'(ram_rw),    32'd1);
    check({tag, "_ram_a"},     32'(ram_a),     32'd0);
    check({tag, "_ram_d_out"}, 32'(ram_d_out), 32'd0);
    check({tag, "_ram_d_oe"},  32'(ram_d_oe),  32'd0);
    check({tag, "_ram_level"}, 32'(ram_level), 32'd0);
  endtask

  task automatic drain(input string name);
    int c = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((sb.size() != 0 || out_valid) && c < 6000) begin
      @(posedge sys_clk); #1;
      c++;
    end
    check({name, "_drained"}, 32'(sb.size()), 32'd0);
    check({name, "_out_valid"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int lat;
    int d;
    int stall;
    int cyc;
    logic acc;
    resetl = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    #12;
    chk_reset_outs("rst0");
    @(posedge sys_clk); #1 resetl = 1'b1;
    @(posedge sys_clk); #1;

    // Single word latency
    first_wr = -1; first_rd = -1; cen_low_seen = 0;
    in_valid = 1'b1; in_data = 16'h1234; out_ready = 1'b1;
    @(posedge sys_clk); #1 in_valid = 1'b0;
    lat = -1;
    for (int e = 1; e <= 12; e++) begin
      if (lat < 0 && out_valid) lat = e - 1;
      @(posedge sys_clk); #1;
      if (lat < 0 && out_valid) lat = e;
    end
`ifdef LBUF_BYPASS_EN
    check("latency", 32'(lat), 32'd1);
    check("no_ram_access", 32'(cen_low_seen), 32'd0);
`else
    check("latency", 32'(lat), 32'd5);
    check("first_wr_addr", 32'(first_wr), 32'd0);
    check("first_rd_addr", 32'(first_rd), 32'd0);
`endif
    check("sb_empty_t1", 32'(sb.size()), 32'd0);

    // Fill to capacity with consumer stalled
    out_ready = 1'b0; d = 0; stall = 0; cyc = 0;
    in_valid = 1'b1; in_data = 16'(d);
    while (stall < 30 && cyc < 2000) begin
      @(negedge sys_clk) acc = in_ready;
      @(posedge sys_clk); #1;
      cyc++;
      if (acc) begin d++; stall = 0; end else stall++;
      in_data = 16'(d);
    end
    check("fill_accepted", 32'(d), 32'd517);
    check("fill_level", 32'(ram_level), 32'd512);
    check("fill_in_ready", 32'(in_ready), 32'd0);
    drain("fill");

    // Continuous stream of 1200 words
    wrap_seen = 0; d = 0; cyc = 0;
    out_ready = 1'b1; in_valid = 1'b1; in_data = 16'($urandom);
    while (d < 1200 && cyc < 6000) begin
      @(negedge sys_clk) acc = in_ready;
      @(posedge sys_clk); #1;
      cyc++;
      if (acc) begin d++; in_data = 16'($urandom); end
    end
    check("stream_count", 32'(d), 32'd1200);
    drain("stream");
`ifndef LBUF_BYPASS_EN
    check("addr_wrap", 32'(wrap_seen), 32'd1);
`endif

    // Random handshakes
    for (int i = 0; i < 3000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_data   = 16'($urandom);
      @(posedge sys_clk); #1;
    end
    drain("random");

    // Reset while data is stored and reads are in flight
    out_ready = 1'b0; in_valid = 1'b1; cyc = 0;
    while (ram_level < 10'd37 && cyc < 400) begin
      in_data = 16'($urandom);
      @(posedge sys_clk); #1;
      cyc++;
    end
    check("pre_reset_level", 32'(ram_level >= 10'd37), 32'd1);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge sys_clk); #1;
    @(posedge sys_clk); #1;
    out_ready = 1'b0;
    #2 resetl = 1'b0;
    #1 chk_reset_outs("rst_mid");
    sb.delete();
    @(posedge sys_clk); #1;
    @(posedge sys_clk); #1;
    check("rst_hold_level", 32'(ram_level), 32'd0);
    resetl = 1'b1;
    @(posedge sys_clk); #1;
    want_first = 1;
    in_valid = 1'b1; in_data = 16'hBEEF; out_ready = 1'b1;
    @(posedge sys_clk); #1 in_valid = 1'b0;
    drain("post_reset");
    check("beef_seen", 32'(want_first), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
